// File: rtl/hood_mode_controller.sv
// hood_mode_controller: operating-mode sequencer for the range hood.
// Takes the power level and debounced one-cycle key pulses, runs the mode
// state machine with per-mode countdown timers, and drives the fan level
// plus mode code / remaining seconds for the display path.
// Optional feature macro: LVL3_ONCE_EN (level 3 usable once per power cycle).
// Valid/ready: there is no handshake here; every *_pulse input is a one-cycle
// strobe that is sampled on each rising clk edge and either acted on or dropped.
module hood_mode_controller #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int LVL3_SEC  = 60,
  parameter int EXIT_SEC  = 60,
  parameter int CLEAN_SEC = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       menu_pulse,
  input  logic       lvl1_pulse,
  input  logic       lvl2_pulse,
  input  logic       lvl3_pulse,
  input  logic       clean_pulse,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] remaining_sec,
  output logic       done_pulse
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STANDBY = 3'd1,
    S_MENU    = 3'd2,
    S_LVL1    = 3'd3,
    S_LVL2    = 3'd4,
    S_LVL3    = 3'd5,
    S_EXIT    = 3'd6,
    S_CLEAN   = 3'd7
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [7:0]    rem_nx;
  logic [1:0]    fan_nx;
  logic          done_nx;
  logic          tick;
  logic          lvl3_ok;

`ifdef LVL3_ONCE_EN
  logic lvl3_used, lvl3_used_nx;
  assign lvl3_ok = !lvl3_used;
`else
  assign lvl3_ok = 1'b1;
`endif

  // The state register is the mode code, so the mode output is registered.
  assign mode = state;
  assign tick = (presc == PRESC_LAST);

  function automatic logic [1:0] fan_of(input state_t s);
    case (s)
      S_LVL1:         fan_of = 2'd1;
      S_LVL2:         fan_of = 2'd2;
      S_LVL3, S_EXIT: fan_of = 2'd3;
      default:        fan_of = 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] load_of(input state_t s);
    case (s)
      S_LVL3:  load_of = 8'(LVL3_SEC);
      S_EXIT:  load_of = 8'(EXIT_SEC);
      S_CLEAN: load_of = 8'(CLEAN_SEC);
      default: load_of = 8'd0;
    endcase
  endfunction

  // Next-state, timer and output logic; pulses are tested in priority order
  // menu > lvl3 > lvl2 > lvl1 > clean so only the highest legal one acts.
  always_comb begin
    state_nx = state;
    rem_nx   = remaining_sec;
    presc_nx = tick ? '0 : presc + PW'(1);
    done_nx  = 1'b0;
`ifdef LVL3_ONCE_EN
    lvl3_used_nx = lvl3_used;
`endif
    if (!power_on) begin
      state_nx = S_OFF;
      rem_nx   = 8'd0;
      presc_nx = '0;
`ifdef LVL3_ONCE_EN
      lvl3_used_nx = 1'b0;
`endif
    end else begin
      case (state)
        S_OFF:     state_nx = S_STANDBY;
        S_STANDBY: if (menu_pulse) state_nx = S_MENU;
        S_MENU: begin
          if (menu_pulse)                  state_nx = S_STANDBY;
          else if (lvl3_pulse && lvl3_ok)  state_nx = S_LVL3;
          else if (lvl2_pulse)             state_nx = S_LVL2;
          else if (lvl1_pulse)             state_nx = S_LVL1;
          else if (clean_pulse)            state_nx = S_CLEAN;
        end
        S_LVL1: begin
          if (menu_pulse)      state_nx = S_STANDBY;
          else if (lvl2_pulse) state_nx = S_LVL2;
        end
        S_LVL2: begin
          if (menu_pulse)      state_nx = S_STANDBY;
          else if (lvl1_pulse) state_nx = S_LVL1;
        end
        S_LVL3: begin
          // A menu press wins over a same-cycle expiry.
          if (menu_pulse) state_nx = S_EXIT;
          else if (tick) begin
            if (remaining_sec <= 8'd1) state_nx = S_LVL2;
            else                       rem_nx   = remaining_sec - 8'd1;
          end
        end
        S_EXIT: begin
          if (tick) begin
            if (remaining_sec <= 8'd1) state_nx = S_STANDBY;
            else                       rem_nx   = remaining_sec - 8'd1;
          end
        end
        S_CLEAN: begin
          if (tick) begin
            if (remaining_sec <= 8'd1) begin
              state_nx = S_STANDBY;
              done_nx  = 1'b1;
            end else begin
              rem_nx = remaining_sec - 8'd1;
            end
          end
        end
        default: state_nx = S_OFF;
      endcase
    end
    // Every state entry restarts the second and loads the new countdown.
    if (state_nx != state) begin
      presc_nx = '0;
      rem_nx   = load_of(state_nx);
`ifdef LVL3_ONCE_EN
      if (state_nx == S_LVL3) lvl3_used_nx = 1'b1;
`endif
    end
    fan_nx = fan_of(state_nx);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_OFF;
      presc         <= '0;
      remaining_sec <= 8'd0;
      fan_level     <= 2'd0;
      done_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      presc         <= presc_nx;
      remaining_sec <= rem_nx;
      fan_level     <= fan_nx;
      done_pulse    <= done_nx;
    end
  end

`ifdef LVL3_ONCE_EN
  // Level-3 usage flag, cleared by power-off or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl3_used <= 1'b0;
    else      lvl3_used <= lvl3_used_nx;
  end
`endif

endmodule

// File: tb/tb_hood_mode_controller.sv
// Bench for hood_mode_controller: directed walk through the modes followed by
// random key presses, all checked against a cycle-countdown reference model.
module tb_hood_mode_controller;

  localparam int TD = 4;
  localparam int L3 = 3;
  localparam int EX = 2;
  localparam int CL = 5;

  logic       clk;
  logic       rst;
  logic       power_on;
  logic       menu_pulse;
  logic       lvl1_pulse;
  logic       lvl2_pulse;
  logic       lvl3_pulse;
  logic       clean_pulse;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] remaining_sec;
  logic       done_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode code, cycles left in the timed state, lvl3 usage.
  int m_mode;
  int m_left;
  bit m_used;
  bit m_done;

  hood_mode_controller #(
    .TICK_DIV (TD),
    .LVL3_SEC (L3),
    .EXIT_SEC (EX),
    .CLEAN_SEC(CL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .power_on     (power_on),
    .menu_pulse   (menu_pulse),
    .lvl1_pulse   (lvl1_pulse),
    .lvl2_pulse   (lvl2_pulse),
    .lvl3_pulse   (lvl3_pulse),
    .clean_pulse  (clean_pulse),
    .mode         (mode),
    .fan_level    (fan_level),
    .remaining_sec(remaining_sec),
    .done_pulse   (done_pulse)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int secs_of(input int s);
    case (s)
      5:       secs_of = L3;
      6:       secs_of = EX;
      7:       secs_of = CL;
      default: secs_of = 0;
    endcase
  endfunction

  function automatic int fan_exp(input int s);
    if (s == 3)                fan_exp = 1;
    else if (s == 4)           fan_exp = 2;
    else if (s == 5 || s == 6) fan_exp = 3;
    else                       fan_exp = 0;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_left = 0;
    m_used = 0;
    m_done = 0;
  endtask

  task automatic enter(input int s);
    m_mode = s;
    m_left = secs_of(s) * TD;
    if (s == 5) m_used = 1;
  endtask

  // One clock edge of the model: timed states simply run down a cycle count.
  task automatic model_edge(input bit pw, input bit mn, input bit l1,
                            input bit l2, input bit l3, input bit cl);
    bit l3_ok;
`ifdef LVL3_ONCE_EN
    l3_ok = !m_used;
`else
    l3_ok = 1'b1;
`endif
    m_done = 0;
    if (!pw) begin
      m_mode = 0;
      m_left = 0;
      m_used = 0;
    end else begin
      case (m_mode)
        0: enter(1);
        1: if (mn) enter(2);
        2: begin
          if (mn)              enter(1);
          else if (l3 && l3_ok) enter(5);
          else if (l2)         enter(4);
          else if (l1)         enter(3);
          else if (cl)         enter(7);
        end
        3: if (mn) enter(1); else if (l2) enter(4);
        4: if (mn) enter(1); else if (l1) enter(3);
        5: begin
          if (mn) enter(6);
          else begin
            m_left--;
            if (m_left == 0) enter(4);
          end
        end
        6: begin
          m_left--;
          if (m_left == 0) enter(1);
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            enter(1);
            m_done = 1;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int rem;
    rem = (m_left + TD - 1) / TD;
    chk({tag, ".mode"}, 8'(mode), 8'(m_mode));
    chk({tag, ".fan"},  8'(fan_level), 8'(fan_exp(m_mode)));
    chk({tag, ".rem"},  remaining_sec, 8'(rem));
    chk({tag, ".done"}, 8'(done_pulse), 8'(m_done));
  endtask

  // Driver: hold inputs across one rising edge, advance model, check after.
  task automatic step(input string tag, input bit pw, input bit mn, input bit l1,
                      input bit l2, input bit l3, input bit cl);
    power_on    = pw;
    menu_pulse  = mn;
    lvl1_pulse  = l1;
    lvl2_pulse  = l2;
    lvl3_pulse  = l3;
    clean_pulse = cl;
    @(posedge clk);
    model_edge(pw, mn, l1, l2, l3, cl);
    #1;
    check_all(tag);
    menu_pulse  = 1'b0;
    lvl1_pulse  = 1'b0;
    lvl2_pulse  = 1'b0;
    lvl3_pulse  = 1'b0;
    clean_pulse = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pw, mn, l1, l2, l3, cl;
    rst         = 1'b0;
    power_on    = 1'b0;
    menu_pulse  = 1'b0;
    lvl1_pulse  = 1'b0;
    lvl2_pulse  = 1'b0;
    lvl3_pulse  = 1'b0;
    clean_pulse = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.mode", 8'(mode), 8'd0);
    chk("reset.fan",  8'(fan_level), 8'd0);
    chk("reset.rem",  remaining_sec, 8'd0);
    chk("reset.done", 8'(done_pulse), 8'd0);
    rst = 1'b1;

    // Power-up and basic navigation.
    step("off_hold", 0, 0, 0, 0, 0, 0);
    step("power_up", 1, 0, 0, 0, 0, 0);
    step("to_menu",  1, 1, 0, 0, 0, 0);
    step("to_lvl2",  1, 0, 0, 1, 0, 0);
    step("lvl2_to1", 1, 0, 1, 0, 0, 0);
    step("lvl1_ign", 1, 0, 0, 0, 1, 1);
    step("to_stby",  1, 1, 0, 0, 0, 0);
    step("stby_ign", 1, 0, 1, 1, 1, 1);

    // Level 3 auto-drop to level 2.
    step("to_menu2", 1, 1, 0, 0, 0, 0);
    step("to_lvl3",  1, 0, 0, 0, 1, 0);
    step("lvl3_ign", 1, 0, 1, 1, 0, 1);
    idle("lvl3_run", 12);

    // Second lvl3 request: blocked only with the once-per-power-cycle feature.
    step("l2_stby",  1, 1, 0, 0, 0, 0);
    step("to_menu3", 1, 1, 0, 0, 0, 0);
    step("lvl3_again", 1, 0, 0, 0, 1, 0);
    step("menu_back", 1, 1, 0, 0, 0, 0);
    step("exit_ign", 1, 0, 1, 0, 0, 0);
    idle("exit_run", 10);

    // Self-clean with done pulse.
    step("stby_m",   1, 1, 0, 0, 0, 0);
    step("to_clean", 1, 0, 0, 0, 0, 1);
    step("clean_ign", 1, 1, 0, 0, 0, 0);
    idle("clean_run", 21);

    // Priority: menu beats lvl3 in MENU; lvl2 beats lvl1.
    step("to_menu4", 1, 1, 0, 0, 0, 0);
    step("prio_menu", 1, 1, 0, 0, 1, 0);
    step("to_menu5", 1, 1, 0, 0, 0, 0);
    step("prio_l2",  1, 0, 1, 1, 0, 1);

    // Power cycle re-arms level 3, then power drop inside LVL3.
    step("pwr_off",  0, 0, 0, 0, 0, 0);
    step("pwr_on",   1, 0, 0, 0, 0, 0);
    step("to_menu6", 1, 1, 0, 0, 0, 0);
    step("lvl3_rearm", 1, 0, 0, 0, 1, 0);
    idle("lvl3_part", 5);
    step("pwr_drop", 0, 1, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a timed state.
    step("pwr_on2",  1, 0, 0, 0, 0, 0);
    step("to_menu7", 1, 1, 0, 0, 0, 0);
    step("to_clean2", 1, 0, 0, 0, 0, 1);
    idle("clean_part", 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst.mode", 8'(mode), 8'd0);
    chk("async_rst.rem",  remaining_sec, 8'd0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;

    // Random key presses with occasional power drops.
    for (int i = 0; i < 800; i++) begin
      pw = ($urandom_range(0, 199) != 0);
      mn = ($urandom_range(0, 11) == 0);
      l1 = ($urandom_range(0, 9) == 0);
      l2 = ($urandom_range(0, 9) == 0);
      l3 = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 9) == 0);
      step("rand", pw, mn, l1, l2, l3, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
